hazard3_pmp_loader: RTL and testbench

HAZARD3_PMP_LOADER -- requirements
Module: hazard3_pmp_loader

---
 rtl/hazard3_pmp_loader_pkg.sv | 26 ++
 rtl/hazard3_pmp_legalise.sv | 48 ++++
 rtl/hazard3_pmp_loader.sv | 147 ++++++++++++++
 tb/tb_hazard3_pmp_loader.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard3_pmp_loader_pkg.sv
// Shared definitions for the PMP boot loader: CSR addresses of the PMP
// configuration registers and the loader FSM state encoding.
package hazard3_pmp_loader_pkg;

    // PMP CSR addresses (RISC-V privileged architecture numbering)
    localparam logic [11:0] PMPCFG0  = 12'h3A0;
    localparam logic [11:0] PMPADDR0 = 12'h3B0;

    // pmpcfg registers each pack four 8-bit region configs on RV32
    localparam int REGIONS_PER_CFG = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WRITE = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } loader_state_t;

    // Number of pmpcfg words needed to cover a given region count
    function automatic int ncfg(input int regions);
        return (regions + REGIONS_PER_CFG - 1) / REGIONS_PER_CFG;
    endfunction

endpackage

// File: rtl/hazard3_pmp_legalise.sv
// Combinational model of what the PMP CSRs are expected to read back after
// a write: WARL legalisation of a pmpaddr or pmpcfg value.
module hazard3_pmp_legalise
    import hazard3_pmp_loader_pkg::*;
#(
    parameter int PMP_REGIONS = 4,
    parameter int W_DATA      = 32,
    parameter int W_ADDR      = 32
) (
    input  logic              is_cfg,
    input  logic [3:0]        cfg_index,
    input  logic [W_DATA-1:0] wdata,
    output logic [W_DATA-1:0] legal
);

    logic [W_DATA-1:0] addr_legal;
    logic [W_DATA-1:0] cfg_legal;

    // pmpaddr holds address bits [W_ADDR-1:2]; anything above is hardwired zero
    for (genvar gi = 0; gi < W_DATA; gi++) begin : g_addr_bit
        if (gi >= W_ADDR - 2) begin : g_zero
            assign addr_legal[gi] = 1'b0;
        end else begin : g_keep
            assign addr_legal[gi] = wdata[gi];
        end
    end

    // Each cfg byte: L=7, reserved 6:5, A=4:3, X/W/R=2:0. Reserved bits read
    // zero, TOR is not supported (A=01 reads back OFF), and bytes of regions
    // beyond PMP_REGIONS read zero.
    for (genvar gi = 0; gi < REGIONS_PER_CFG; gi++) begin : g_cfg_byte
        localparam logic [1:0] LANE = 2'(gi);
        logic [7:0] b;
        logic [1:0] a_field;
        logic       exists;
        assign b       = wdata[8*gi +: 8];
        assign a_field = (b[4:3] == 2'b01) ? 2'b00 : b[4:3];
        assign exists  = ({cfg_index, LANE} < 6'(PMP_REGIONS));
        assign cfg_legal[8*gi +: 8] = exists ? {b[7], 2'b00, a_field, b[2:0]} : 8'h00;
    end

    if (W_DATA > 8 * REGIONS_PER_CFG) begin : g_cfg_upper
        assign cfg_legal[W_DATA-1:8*REGIONS_PER_CFG] = '0;
    end

    assign legal = is_cfg ? cfg_legal : addr_legal;

endmodule

// File: rtl/hazard3_pmp_loader.sv
// Boot-time PMP loader: copies pmpaddr then pmpcfg values from a table into
// the PMP CSRs, verifies each by readback, and holds the core until done.
module hazard3_pmp_loader
    import hazard3_pmp_loader_pkg::*;
#(
    parameter int PMP_REGIONS = 4,
    parameter int W_DATA      = 32,
    parameter int W_ADDR      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [7:0]        tbl_addr,
    input  logic [W_DATA-1:0] tbl_rdata,
    output logic              cfg_req,
    output logic [11:0]       cfg_addr,
    output logic              cfg_wen,
    output logic [W_DATA-1:0] cfg_wdata,
    input  logic [W_DATA-1:0] cfg_rdata,
    output logic              core_hold,
    output logic              done,
    output logic              err,
    output logic [7:0]        err_index
);

    localparam int          N_ENTRIES = PMP_REGIONS + ncfg(PMP_REGIONS);
    localparam logic [7:0]  LAST_K    = 8'(N_ENTRIES - 1);
    localparam logic [7:0]  N_REG     = 8'(PMP_REGIONS);

    loader_state_t     state_reg, state_next;
    logic [7:0]        k_reg;
    logic [W_DATA-1:0] wdata_reg;
    logic [7:0]        err_index_reg;
    logic              core_hold_reg;

    logic              is_cfg;
    logic [7:0]        cfg_k;
    logic [11:0]       target_addr;
    logic [W_DATA-1:0] expected;
    logic              match;

    // Address entries come first so no lock bit can block an address write
    assign is_cfg      = (k_reg >= N_REG);
    assign cfg_k       = k_reg - N_REG;
    assign target_addr = is_cfg ? (PMPCFG0 + {4'd0, cfg_k}) : (PMPADDR0 + {4'd0, k_reg});
    assign match       = (cfg_rdata == expected);

    hazard3_pmp_legalise #(
        .PMP_REGIONS (PMP_REGIONS),
        .W_DATA      (W_DATA),
        .W_ADDR      (W_ADDR)
    ) u_legalise (
        .is_cfg    (is_cfg),
        .cfg_index (cfg_k[3:0]),
        .wdata     (wdata_reg),
        .legal     (expected)
    );

    // State register; reset abandons any sequence in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Entry index, captured write data, error index and core hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_reg         <= 8'd0;
            wdata_reg     <= '0;
            err_index_reg <= 8'd0;
            core_hold_reg <= 1'b1;
        end else begin
            case (state_reg)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        k_reg         <= 8'd0;
                        err_index_reg <= 8'd0;
                    end
                end
                WRITE: wdata_reg <= tbl_rdata;
                CHECK: begin
                    if (!match) begin
                        err_index_reg <= k_reg;
                    end else if (k_reg == LAST_K) begin
                        core_hold_reg <= 1'b0;
                    end else begin
                        k_reg <= k_reg + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next-state and port outputs decoded from the current state
    always_comb begin
        state_next = state_reg;
        tbl_addr   = 8'd0;
        cfg_req    = 1'b0;
        cfg_addr   = 12'd0;
        cfg_wen    = 1'b0;
        cfg_wdata  = '0;
        done       = 1'b0;
        err        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) state_next = FETCH;
            end
            FETCH: begin
                cfg_req    = 1'b1;
                cfg_addr   = target_addr;
                tbl_addr   = k_reg;
                state_next = WRITE;
            end
            WRITE: begin
                cfg_req    = 1'b1;
                cfg_addr   = target_addr;
                cfg_wen    = 1'b1;
                cfg_wdata  = tbl_rdata;
                state_next = CHECK;
            end
            CHECK: begin
                cfg_req  = 1'b1;
                cfg_addr = target_addr;
                if (!match)              state_next = ERR;
                else if (k_reg == LAST_K) state_next = DONE;
                else                     state_next = FETCH;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_next = FETCH;
            end
            ERR: begin
                err = 1'b1;
                if (start) state_next = FETCH;
            end
            default: state_next = IDLE;
        endcase
    end

    assign err_index = err_index_reg;
    assign core_hold = core_hold_reg;

endmodule

// File: tb/tb_hazard3_pmp_loader.sv
// Directed bench for hazard3_pmp_loader with a registered-read table and a
// small model of the PMP CSR block that legalises on write.
module tb_hazard3_pmp_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  tbl_addr;
    logic [31:0] tbl_rdata;
    logic        cfg_req;
    logic [11:0] cfg_addr;
    logic        cfg_wen;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;
    logic        core_hold;
    logic        done;
    logic        err;
    logic [7:0]  err_index;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] tbl [0:7];
    logic [31:0] pmp_addr [0:3];
    logic [31:0] pmp_cfg0;
    logic        corrupt;
    int          wr_count = 0;
    logic [11:0] wr_addr_log [0:63];
    logic [31:0] wr_data_log [0:63];

    hazard3_pmp_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .tbl_addr  (tbl_addr),
        .tbl_rdata (tbl_rdata),
        .cfg_req   (cfg_req),
        .cfg_addr  (cfg_addr),
        .cfg_wen   (cfg_wen),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .core_hold (core_hold),
        .done      (done),
        .err       (err),
        .err_index (err_index)
    );

    always #5 clk = ~clk;

    // Table memory: data appears one cycle after the address
    always @(posedge clk) tbl_rdata <= tbl[tbl_addr[2:0]];

    // Model PMP: reserved cfg bits drop, TOR (A=01 at bits 4:3) becomes OFF,
    // pmpaddr keeps only 30 bits
    function automatic logic [31:0] pmp_cfg_warl(input logic [31:0] d);
        logic [31:0] r;
        r = d & 32'h9F9F_9F9F;
        for (int i = 0; i < 4; i++)
            if (r[8*i+3 +: 2] == 2'b01) r[8*i+3 +: 2] = 2'b00;
        return r;
    endfunction

    always @(posedge clk) begin
        if (cfg_wen) begin
            wr_addr_log[wr_count[5:0]] <= cfg_addr;
            wr_data_log[wr_count[5:0]] <= cfg_wdata;
            wr_count <= wr_count + 1;
            if (cfg_addr == 12'h3A0) pmp_cfg0 <= pmp_cfg_warl(cfg_wdata);
            else if (cfg_addr[11:2] == 10'b0011_1011_00)
                pmp_addr[cfg_addr[1:0]] <= cfg_wdata & 32'h3FFF_FFFF;
        end
    end

    always @* begin
        cfg_rdata = 32'h0;
        if (cfg_addr == 12'h3A0) cfg_rdata = pmp_cfg0;
        else if (cfg_addr[11:2] == 10'b0011_1011_00) cfg_rdata = pmp_addr[cfg_addr[1:0]];
        if (corrupt && cfg_addr == 12'h3B2) cfg_rdata = cfg_rdata ^ 32'h0000_0100;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-16s observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tbl_addr"},  32'(tbl_addr),  32'h0);
        check({tag, "_cfg_req"},   32'(cfg_req),   32'h0);
        check({tag, "_cfg_addr"},  32'(cfg_addr),  32'h0);
        check({tag, "_cfg_wen"},   32'(cfg_wen),   32'h0);
        check({tag, "_cfg_wdata"}, cfg_wdata,      32'h0);
        check({tag, "_done"},      32'(done),      32'h0);
        check({tag, "_err"},       32'(err),       32'h0);
        check({tag, "_err_index"}, 32'(err_index), 32'h0);
        check({tag, "_core_hold"}, 32'(core_hold), 32'h1);
    endtask

    // Start is sampled on the posedge between the two negedges; returns
    // at the negedge after that sampling edge (cycle 0)
    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // Counts edges after the start edge until done or err, bounded
    task automatic wait_end(input int from, output int cyc);
        cyc = from;
        while (!(done || err) && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    int cyc;
    int base;
    logic [11:0] exp_addr [0:4];

    initial begin
        exp_addr[0] = 12'h3B0; exp_addr[1] = 12'h3B1; exp_addr[2] = 12'h3B2;
        exp_addr[3] = 12'h3B3; exp_addr[4] = 12'h3A0;
        for (int i = 0; i < 8; i++) tbl[i] = 32'h0;
        tbl[0] = 32'h2000_03FF; tbl[1] = 32'h0000_0FFF; tbl[2] = 32'h2004_0001;
        tbl[3] = 32'h3FFF_FFFF; tbl[4] = 32'h009F_1B0F;
        for (int i = 0; i < 4; i++) pmp_addr[i] = 32'h0;
        pmp_cfg0 = 32'h0;
        corrupt  = 1'b0;
        start    = 1'b0;
        rst_n    = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_core_hold", 32'(core_hold), 32'h1);
        check("idle_cfg_req",   32'(cfg_req),   32'h0);

        // Readback of PMPADDR2 corrupted: stop at entry 2 after 9 cycles
        corrupt = 1'b1;
        base = wr_count;
        pulse_start();
        wait_end(0, cyc);
        check("err_cycles",    32'(cyc),       32'd9);
        check("err_flag",      32'(err),       32'h1);
        check("err_done",      32'(done),      32'h0);
        check("err_index",     32'(err_index), 32'h2);
        check("err_writes",    32'(wr_count - base), 32'd3);
        repeat (10) @(negedge clk);
        check("err_no_wen",    32'(wr_count - base), 32'd3);
        check("err_sticky",    32'(err),       32'h1);
        check("err_core_hold", 32'(core_hold), 32'h1);
        check("err_cfg_req",   32'(cfg_req),   32'h0);

        // Restart from ERR with a clean PMP: full load in 15 cycles
        corrupt = 1'b0;
        base = wr_count;
        pulse_start();
        check("rs_err_clear", 32'(err),      32'h0);
        check("rs_fetch_tbl", 32'(tbl_addr), 32'h0);
        check("rs_fetch_req", 32'(cfg_req),  32'h1);
        check("rs_fetch_csr", 32'(cfg_addr), 32'h3B0);
        check("rs_fetch_wen", 32'(cfg_wen),  32'h0);
        wait_end(0, cyc);
        check("load_cycles",  32'(cyc),       32'd15);
        check("load_done",    32'(done),      32'h1);
        check("load_err",     32'(err),       32'h0);
        check("load_hold",    32'(core_hold), 32'h0);
        check("load_writes",  32'(wr_count - base), 32'd5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("wr%0d_addr", i), 32'(wr_addr_log[(base + i) % 64]), 32'(exp_addr[i]));
            check($sformatf("wr%0d_data", i), wr_data_log[(base + i) % 64], tbl[i]);
        end
        // 0x0F is TOR -> 0x07; 0x1B and 0x9F are already legal
        check("load_pmpcfg0", pmp_cfg0, 32'h009F_1B07);

        // Second start from DONE, with an extra start pulsed during WRITE
        base = wr_count;
        pulse_start();
        check("re_done_clear", 32'(done), 32'h0);
        @(negedge clk);
        check("re_write_wen",  32'(cfg_wen),   32'h1);
        check("re_write_data", cfg_wdata,      32'h2000_03FF);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_end(2, cyc);
        check("re_cycles", 32'(cyc),  32'd15);
        check("re_done",   32'(done), 32'h1);
        check("re_writes", 32'(wr_count - base), 32'd5);
        check("re_hold",   32'(core_hold), 32'h0);

        // Cfg byte0 = 0x0D (A=01, X, R) reads back as 0x05 and is accepted
        tbl[4] = 32'h009F_1B0D;
        pulse_start();
        wait_end(0, cyc);
        check("tor_cycles", 32'(cyc),  32'd15);
        check("tor_done",   32'(done), 32'h1);
        check("tor_err",    32'(err),  32'h0);
        check("tor_pmpcfg", pmp_cfg0,  32'h009F_1B05);

        // Reset asserted during CHECK of entry 3
        pulse_start();
        repeat (11) @(negedge clk);
        check("mid_chk_addr", 32'(cfg_addr), 32'h3B3);
        check("mid_chk_wen",  32'(cfg_wen),  32'h0);
        base = wr_count;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("mid_no_writes", 32'(wr_count - base), 32'd0);
        check("mid_hold",      32'(core_hold), 32'h1);
        check("mid_done",      32'(done),      32'h0);
        check("mid_cfg_req",   32'(cfg_req),   32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
